// File: rtl/dma_bram_pkg.sv
// Shared types and sizing helpers for the block-RAM backed bsg_cache DMA responder.
// The packet struct is given at the default 32-bit address width for benches and tooling.
package dma_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_e;

    localparam int unsigned default_caddr_width = 32;

    typedef struct packed {
        logic                           write_not_read;
        logic [default_caddr_width-1:0] addr;
    } dma_pkt_s;

    function automatic int unsigned beats_per_block(input int unsigned block_width,
                                                    input int unsigned fill_width);
        return block_width / fill_width;
    endfunction

    // Number of byte-address bits below one fill word.
    function automatic int unsigned word_offset_width(input int unsigned fill_width);
        return $clog2(fill_width / 8);
    endfunction

    function automatic int unsigned beat_cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/dma_bram_responder_ram.sv
// Single-port synchronous RAM with one-cycle read latency; the read word is held
// on the output until the next read, which lets the responder stall a beat for free.
module dma_bram_responder_ram #(
    parameter int unsigned width = 64,
    parameter int unsigned els   = 4096,
    parameter int unsigned addr_width = $clog2(els)
) (
    input  logic                  clk,
    input  logic                  v,
    input  logic                  w,
    input  logic [addr_width-1:0] addr,
    input  logic [width-1:0]      data,
    output logic [width-1:0]      q
);

    logic [width-1:0] mem [els];

    // NOTE: the array and its read register carry no reset so the tool can map them
    // onto block RAM; contents survive reset and valid qualifiers guard the output.
    always_ff @(posedge clk) begin
        if (v) begin
            if (w) begin
                mem[addr] <= data;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dma_bram_responder.sv
// Memory-side responder for the bsg_cache DMA interface backed by on-chip block RAM.
// Packets are strictly serialized: read fills stream beats, write-backs absorb beats.
module dma_bram_responder
    import dma_bram_pkg::*;
#(
    parameter int unsigned caddr_width_p = 32,
    parameter int unsigned fill_width_p  = 64,
    parameter int unsigned block_width_p = 512,
    parameter int unsigned mem_els_p     = 4096,
    localparam int unsigned dma_pkt_width_lp = 1 + caddr_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_yumi_o,

    output logic [fill_width_p-1:0]     dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_and_i,

    input  logic [fill_width_p-1:0]     dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_yumi_o
);

    localparam int unsigned beats     = beats_per_block(block_width_p, fill_width_p);
    localparam int unsigned off_w     = word_offset_width(fill_width_p);
    localparam int unsigned cnt_w     = beat_cnt_width(beats);
    localparam int unsigned idx_w     = $clog2(mem_els_p);
    localparam int unsigned blk_w     = idx_w - cnt_w;
    localparam int unsigned blk_lsb   = off_w + cnt_w;
    localparam int unsigned alias_lsb = off_w + idx_w;
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

    typedef struct packed {
        logic                     write_not_read;
        logic [caddr_width_p-1:0] addr;
    } pkt_t;

    pkt_t pkt;
    assign pkt = pkt_t'(dma_pkt_i);

    state_e            state_r;
    logic [blk_w-1:0]  base_r;
    logic [cnt_w-1:0]  cnt_r;
    logic              issued_all_r;
    logic              out_v_r;

    logic              pkt_yumi;
    logic              wr_yumi;
    logic              rd_issue;
    logic              rd_hs;
    logic              rd_done;
    logic              ram_v;
    logic [idx_w-1:0]  ram_addr;

    // Only the block-index bits of the address select RAM; beat offset and
    // high bits are dropped so addresses alias modulo the RAM size.
    logic addr_unused;
    assign addr_unused = ^{pkt.addr[caddr_width_p-1:alias_lsb], pkt.addr[blk_lsb-1:0]};

    assign pkt_yumi = reset_n_i & (state_r == ST_IDLE) & dma_pkt_v_i;
    assign wr_yumi  = (state_r == ST_WRITE) & dma_data_v_i;
    assign rd_hs    = (state_r == ST_READ) & out_v_r & dma_data_ready_and_i;
    assign rd_issue = (state_r == ST_READ) & ~issued_all_r & (~out_v_r | dma_data_ready_and_i);

    // Once every beat is issued, the beat on the output is the last one.
    assign rd_done  = rd_hs & issued_all_r;

    assign ram_v    = rd_issue | wr_yumi;
    assign ram_addr = {base_r, cnt_r};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= ST_IDLE;
            base_r       <= '0;
            cnt_r        <= '0;
            issued_all_r <= 1'b0;
            out_v_r      <= 1'b0;
        end else begin
            unique case (state_r)
                ST_IDLE: begin
                    if (pkt_yumi) begin
                        base_r       <= pkt.addr[blk_lsb +: blk_w];
                        cnt_r        <= '0;
                        issued_all_r <= 1'b0;
                        state_r      <= pkt.write_not_read ? ST_WRITE : ST_READ;
                    end
                end

                ST_READ: begin
                    // An issue in the same cycle as a handshake keeps the output valid.
                    if (rd_issue) begin
                        out_v_r <= 1'b1;
                        if (cnt_r == last_beat) begin
                            issued_all_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + cnt_w'(1);
                        end
                    end else if (rd_hs) begin
                        out_v_r <= 1'b0;
                    end
                    if (rd_done) begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_WRITE: begin
                    if (wr_yumi) begin
                        cnt_r <= cnt_r + cnt_w'(1);
                        if (cnt_r == last_beat) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    dma_bram_responder_ram #(
        .width      (fill_width_p),
        .els        (mem_els_p),
        .addr_width (idx_w)
    ) u_ram (
        .clk  (clk_i),
        .v    (ram_v),
        .w    (wr_yumi),
        .addr (ram_addr),
        .data (dma_data_i),
        .q    (dma_data_o)
    );

    assign dma_pkt_yumi_o  = pkt_yumi;
    assign dma_data_v_o    = out_v_r;
    assign dma_data_yumi_o = wr_yumi;

endmodule

// File: tb/tb_dma_bram_responder.sv
// Randomized bench for dma_bram_responder against a word-array model of the RAM
// addressed by block-aligned word index; directed scenarios first, then random traffic.
module tb_dma_bram_responder;
    import dma_bram_pkg::*;

    localparam int unsigned BEATS   = 8;
    localparam int unsigned MEM_ELS = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [32:0] dma_pkt = '0;
    logic        dma_pkt_v = 1'b0;
    logic        dma_pkt_yumi;
    logic [63:0] dma_data_out;
    logic        dma_data_v_out;
    logic        dma_data_ready = 1'b0;
    logic [63:0] dma_data_in = '0;
    logic        dma_data_v_in = 1'b0;
    logic        dma_data_yumi;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] model_mem [MEM_ELS];
    bit          written_blk [MEM_ELS/BEATS];

    always #5 clk = ~clk;

    dma_bram_responder dut (
        .clk_i                (clk),
        .reset_n_i            (reset_n),
        .dma_pkt_i            (dma_pkt),
        .dma_pkt_v_i          (dma_pkt_v),
        .dma_pkt_yumi_o       (dma_pkt_yumi),
        .dma_data_o           (dma_data_out),
        .dma_data_v_o         (dma_data_v_out),
        .dma_data_ready_and_i (dma_data_ready),
        .dma_data_i           (dma_data_in),
        .dma_data_v_i         (dma_data_v_in),
        .dma_data_yumi_o      (dma_data_yumi)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // First word of the block that a byte address maps to.
    function automatic int unsigned blk_base(input logic [31:0] addr);
        int unsigned word;
        word = (int'(addr >> 3)) % MEM_ELS;
        return word - (word % BEATS);
    endfunction

    function automatic logic [32:0] make_pkt(input bit wnr, input logic [31:0] addr);
        dma_pkt_s p;
        p.write_not_read = wnr;
        p.addr           = addr;
        return p;
    endfunction

    task automatic issue_pkt(input bit wnr, input logic [31:0] addr);
        int waited = 0;
        @(negedge clk);
        dma_pkt        = make_pkt(wnr, addr);
        dma_pkt_v      = 1'b1;
        dma_data_v_in  = 1'b0;
        dma_data_ready = 1'b0;
        #1;
        while (!dma_pkt_yumi && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("pkt_yumi", 64'(dma_pkt_yumi), 64'd1);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
    // abort_after > 0 returns right after that many handshakes.
    task automatic read_beats(input logic [31:0] addr, input int mode, input int abort_after,
                              input bit hold_next, input bit next_wnr, input logic [31:0] next_addr);
        int unsigned base;
        int          hs = 0;
        int          cyc = 0;
        int          last_cyc = 0;
        bit          seen_v = 1'b0;
        logic        prev_v = 1'b0;
        logic        prev_rdy = 1'b1;
        logic [63:0] prev_d = '0;
        base = blk_base(addr);
        while (hs < BEATS && cyc < 200) begin
            @(negedge clk);
            cyc++;
            dma_pkt_v = hold_next;
            dma_pkt   = make_pkt(next_wnr, next_addr);
            case (mode)
                0:       dma_data_ready = 1'b1;
                1:       dma_data_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: dma_data_ready = 1'($urandom_range(0, 1));
            endcase
            dma_data_v_in = 1'($urandom_range(0, 1));
            dma_data_in   = {$urandom, $urandom};
            #1;
            check("data_yumi_in_read", 64'(dma_data_yumi), 64'd0);
            if (hold_next) check("pkt_yumi_during_read", 64'(dma_pkt_yumi), 64'd0);
            if (prev_v && !prev_rdy) begin
                check("hold_valid", 64'(dma_data_v_out), 64'd1);
                check("hold_data", dma_data_out, prev_d);
            end
            if (dma_data_v_out && !seen_v) begin
                seen_v = 1'b1;
                check("first_beat_latency", 64'(cyc), 64'd2);
            end
            if (dma_data_v_out && dma_data_ready) begin
                check("read_data", dma_data_out, model_mem[base + hs]);
                if (mode == 0 && hs > 0) check("back_to_back", 64'(cyc - last_cyc), 64'd1);
                last_cyc = cyc;
                hs++;
                if (hs == abort_after) return;
            end
            prev_v   = dma_data_v_out;
            prev_rdy = dma_data_ready;
            prev_d   = dma_data_out;
        end
        check("read_handshakes", 64'(hs), 64'(BEATS));
        @(negedge clk);
        dma_pkt_v      = hold_next;
        dma_data_v_in  = 1'b0;
        dma_data_ready = 1'b1;
        #1;
        check("no_extra_beat", 64'(dma_data_v_out), 64'd0);
        if (hold_next) check("pkt_yumi_after_read", 64'(dma_pkt_yumi), 64'd1);
    endtask

    // mode 0: valid every cycle, 1: valid every 4th cycle, 2: random valid.
    task automatic write_beats(input logic [31:0] addr, input int mode, input bit seq_data,
                               input bit hold_next, input bit next_wnr, input logic [31:0] next_addr);
        int unsigned base;
        int          idx = 0;
        int          cyc = 0;
        logic        v;
        logic [63:0] d;
        base = blk_base(addr);
        while (idx < BEATS && cyc < 300) begin
            @(negedge clk);
            cyc++;
            dma_pkt_v      = hold_next;
            dma_pkt        = make_pkt(next_wnr, next_addr);
            dma_data_ready = 1'($urandom_range(0, 1));
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 4 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = seq_data ? 64'(32'h1000 + idx) : {$urandom, $urandom};
            dma_data_v_in = v;
            dma_data_in   = d;
            #1;
            check("data_yumi", 64'(dma_data_yumi), 64'(v));
            check("data_v_in_write", 64'(dma_data_v_out), 64'd0);
            if (hold_next) check("pkt_yumi_during_write", 64'(dma_pkt_yumi), 64'd0);
            if (v) begin
                model_mem[base + idx] = d;
                idx++;
            end
        end
        written_blk[base / BEATS] = 1'b1;
        @(negedge clk);
        dma_pkt_v     = hold_next;
        dma_data_v_in = 1'b0;
        #1;
        if (hold_next) check("pkt_yumi_after_write", 64'(dma_pkt_yumi), 64'd1);
    endtask

    task automatic idle_checks();
        @(negedge clk);
        dma_pkt_v      = 1'b0;
        dma_data_v_in  = 1'b1;
        dma_data_ready = 1'b1;
        #1;
        check("idle_data_yumi", 64'(dma_data_yumi), 64'd0);
        check("idle_data_v", 64'(dma_data_v_out), 64'd0);
        dma_data_v_in = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: outputs low even with requests pending.
        dma_pkt_v     = 1'b1;
        dma_data_v_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_pkt_yumi", 64'(dma_pkt_yumi), 64'd0);
        check("reset_data_v", 64'(dma_data_v_out), 64'd0);
        check("reset_data_yumi", 64'(dma_data_yumi), 64'd0);
        @(negedge clk);
        dma_pkt_v     = 1'b0;
        dma_data_v_in = 1'b0;
        reset_n       = 1'b1;
        idle_checks();

        // Write then read with sequential data at a high address.
        issue_pkt(1'b1, 32'h8000_0040);
        write_beats(32'h8000_0040, 0, 1'b1, 1'b0, 1'b0, 32'h0);
        issue_pkt(1'b0, 32'h8000_0040);
        read_beats(32'h8000_0040, 0, 0, 1'b0, 1'b0, 32'h0);

        // Read with backpressure.
        issue_pkt(1'b0, 32'h8000_0040);
        read_beats(32'h8000_0040, 1, 0, 1'b0, 1'b0, 32'h0);

        // Stalled write with a read packet waiting behind it.
        issue_pkt(1'b1, 32'h0000_0100);
        write_beats(32'h0000_0100, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
        read_beats(32'h0000_0100, 0, 0, 1'b0, 1'b0, 32'h0);
        idle_checks();

        // Aliasing: RAM-size alias and beat-offset bits ignored.
        issue_pkt(1'b1, 32'h0000_0000);
        write_beats(32'h0000_0000, 2, 1'b0, 1'b0, 1'b0, 32'h0);
        issue_pkt(1'b0, 32'h0000_8000);
        read_beats(32'h0000_8000, 2, 0, 1'b0, 1'b0, 32'h0);
        issue_pkt(1'b0, 32'h0000_0048);
        read_beats(32'h0000_0048, 0, 0, 1'b0, 1'b0, 32'h0);

        // Serialization: next packet held valid during a read.
        issue_pkt(1'b0, 32'h0000_0000);
        read_beats(32'h0000_0000, 2, 0, 1'b1, 1'b0, 32'h8000_0040);
        read_beats(32'h8000_0040, 0, 0, 1'b0, 1'b0, 32'h0);

        // Reset after three beats of a read.
        issue_pkt(1'b0, 32'h0000_0100);
        read_beats(32'h0000_0100, 0, 3, 1'b0, 1'b0, 32'h0);
        #2;
        reset_n       = 1'b0;
        dma_pkt_v     = 1'b1;
        dma_data_v_in = 1'b1;
        #1;
        check("midreset_data_v", 64'(dma_data_v_out), 64'd0);
        check("midreset_pkt_yumi", 64'(dma_pkt_yumi), 64'd0);
        check("midreset_data_yumi", 64'(dma_data_yumi), 64'd0);
        repeat (2) @(negedge clk);
        dma_pkt_v     = 1'b0;
        dma_data_v_in = 1'b0;
        reset_n       = 1'b1;
        issue_pkt(1'b0, 32'h0000_0100);
        read_beats(32'h0000_0100, 0, 0, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a;
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom;
                issue_pkt(1'b1, a);
                write_beats(a, int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0, 32'h0);
            end else begin
                int unsigned blk;
                blk = $urandom_range(0, MEM_ELS/BEATS - 1);
                while (!written_blk[blk]) blk = (blk + 1) % (MEM_ELS/BEATS);
                a = ($urandom & 32'hFFFF_8000) | (blk * 64) | $urandom_range(0, 63);
                issue_pkt(1'b0, a);
                read_beats(a, int'($urandom_range(0, 2)), 0, 1'b0, 1'b0, 32'h0);
            end
        end
        idle_checks();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
